// File: rtl/fir_top_64_pkg.sv
// Shared constants, coefficient and stimulus functions for the 64-tap FIR block.
package fir_top_64_pkg;

  localparam int NTAPS = 64;
  localparam int NSAMP = 64;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACCW  = 38;

  // Fixed coefficient ramp h[k] = k+1.
  function automatic logic signed [CW-1:0] h(input int k);
    return CW'(k + 1);
  endfunction

  // Internal stimulus: 0 = ramp n+1, 1 = constant full-scale positive.
  function automatic logic signed [DW-1:0] x(input int n, input int stim);
    return (stim == 1) ? 16'sh7FFF : DW'(n + 1);
  endfunction

endpackage

// File: rtl/fir_top_64_if.sv
// Sample/sum bus between the FIR control logic and the datapath core, plus a
// read-port bundle for host-side access to the result memory.
interface fir_top_64_if;
  import fir_top_64_pkg::*;

  logic                   shift_vld;
  logic signed [DW-1:0]   sample_dat;
  logic signed [ACCW-1:0] sum_dat;

  modport master (output shift_vld, output sample_dat, input sum_dat);
  modport slave  (input shift_vld, input sample_dat, output sum_dat);
endinterface

interface fir_top_64_rd_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        done;

  modport master (output addr, input data, input done);
  modport slave  (input addr, output data, output done);
endinterface

// File: rtl/fir_top_64_core.sv
// FIR datapath: 64-entry delay line, 64 multipliers and a combinational 38-bit sum
// of the taps as they currently stand.
module fir_top_64_core
  import fir_top_64_pkg::*;
(
  input logic         clk,
  input logic         reset,
  fir_top_64_if.slave bus
);

  logic signed [DW-1:0]    tap_q [NTAPS];
  logic signed [DW+CW-1:0] prod  [NTAPS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) tap_q[i] <= '0;
    end else if (bus.shift_vld) begin
      tap_q[0] <= bus.sample_dat;
      for (int i = 1; i < NTAPS; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NTAPS; k++) prod[k] = tap_q[k] * h(k);
  end

  // Every product is sign-extended before summing, so 38 bits never overflow.
  always_comb begin
    logic signed [ACCW-1:0] acc;
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + ACCW'(prod[k]);
    bus.sum_dat = acc;
  end

endmodule

// File: rtl/fir_top_64.sv
// FIR top: sample sequencing, overflow reduction to OW bits, 64-word result memory,
// done flag and read mux. FIR_TOP_64_SAT_EN selects saturation instead of wrap.
module fir_top_64
  import fir_top_64_pkg::*;
#(
  parameter int STIM = 0,
  parameter int OW   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] regAddr,
  output logic [31:0] regData,
  output logic        done
);

  localparam int CNTW = $clog2(NSAMP + 1);
  localparam int AW   = $clog2(NSAMP);

  fir_top_64_if core_bus ();

  fir_top_64_core u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (core_bus.slave)
  );

  logic [CNTW-1:0]    cnt_q, cnt_d, cnt_m1;
  logic               done_q, done_d;
  logic [31:0]        res_q [NSAMP];
  logic               wr_en;
  logic [AW-1:0]      wr_idx;
  logic signed [OW-1:0] red;
  logic [31:0]        res_word;

  assign core_bus.shift_vld  = (cnt_q < CNTW'(NSAMP));
  assign core_bus.sample_dat = x(int'(cnt_q), STIM);

  // The sum seen at an edge belongs to the sample shifted in one edge earlier.
  assign cnt_m1 = cnt_q - CNTW'(1);
  assign wr_idx = cnt_m1[AW-1:0];
  assign wr_en  = (cnt_q != '0) && !done_q;

  assign cnt_d  = core_bus.shift_vld ? cnt_q + CNTW'(1) : cnt_q;
  assign done_d = done_q | (cnt_q == CNTW'(NSAMP));

`ifdef FIR_TOP_64_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (core_bus.sum_dat > SAT_MAX)      red = OW'(SAT_MAX);
    else if (core_bus.sum_dat < SAT_MIN) red = OW'(SAT_MIN);
    else                                 red = OW'(core_bus.sum_dat);
  end
`else
  assign red = OW'(core_bus.sum_dat);
`endif

  assign res_word = 32'(red);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NSAMP; i++) res_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (wr_en) res_q[wr_idx] <= res_word;
    end
  end

  assign regData = (regAddr < 32'(NSAMP)) ? res_q[regAddr[AW-1:0]] : '0;
  assign done    = done_q;

endmodule

// File: tb/tb_fir_top_64.sv
// Bench for fir_top_64: ramp/OW=32 and constant/OW=24 instances against an arithmetic model.
module tb_fir_top_64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_top_64_rd_if rd_a ();
  fir_top_64_rd_if rd_b ();

  fir_top_64 #(.STIM(0), .OW(32)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .regAddr (rd_a.addr),
    .regData (rd_a.data),
    .done    (rd_a.done)
  );

  fir_top_64 #(.STIM(1), .OW(24)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .regAddr (rd_b.addr),
    .regData (rd_b.data),
    .done    (rd_b.done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint xs(input int stim, input int m);
    if (m < 0) return 0;
    return (stim == 1) ? 64'sd32767 : longint'(m + 1);
  endfunction

  function automatic longint yref(input int stim, input int n);
    longint s = 0;
    for (int k = 0; k < 64; k++) s += longint'(k + 1) * xs(stim, n - k);
    return s;
  endfunction

  function automatic logic [31:0] reduce(input longint s_in, input int ow);
    longint s   = s_in;
    longint lim = 64'sd1 <<< (ow - 1);
`ifdef FIR_TOP_64_SAT_EN
    if (s > lim - 1)   s = lim - 1;
    else if (s < -lim) s = -lim;
`else
    s = s & ((lim <<< 1) - 1);
    if (s >= lim) s = s - (lim <<< 1);
`endif
    return s[31:0];
  endfunction

  // Expected read value given how many results have been written so far.
  function automatic logic [31:0] exp_word(input int stim, input int ow,
                                           input logic [31:0] addr, input int n_wr);
    if (addr >= 32'd64) return 32'd0;
    if (int'(addr) >= n_wr) return 32'd0;
    return reduce(yref(stim, int'(addr)), ow);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'($urandom_range(0, 70));
  endfunction

  task automatic rand_reads(input string ph, input int k);
    int n_wr = (k < 64) ? k : 64;
    for (int r = 0; r < 2; r++) begin
      rd_a.addr = rand_addr();
      rd_b.addr = rand_addr();
      #1;
      chk($sformatf("%s a rd[%0h]@E%0d", ph, rd_a.addr, k), rd_a.data, exp_word(0, 32, rd_a.addr, n_wr));
      chk($sformatf("%s b rd[%0h]@E%0d", ph, rd_b.addr, k), rd_b.data, exp_word(1, 24, rd_b.addr, n_wr));
    end
  endtask

  // Reset must already be released at a falling edge; the next rising edge is E0.
  task automatic run_seq(input string ph, input int stop_at);
    for (int k = 0; k <= 68; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s done_a@E%0d", ph, k), 32'(rd_a.done), 32'(k >= 64));
      chk($sformatf("%s done_b@E%0d", ph, k), 32'(rd_b.done), 32'(k >= 64));
      if (k == 11) begin
        rd_a.addr = 32'd10;
        #1;
        chk($sformatf("%s a result10@E11", ph), rd_a.data, 32'd286);
      end
      rand_reads(ph, k);
      if (k == stop_at) return;
    end
  endtask

  task automatic sweep(input string ph);
    for (int j = 0; j < 64; j++) begin
      rd_a.addr = 32'(j);
      rd_b.addr = 32'(j);
      #1;
      chk($sformatf("%s a C(n+3,3) n=%0d", ph, j), rd_a.data, 32'((j + 1) * (j + 2) * (j + 3) / 6));
      chk($sformatf("%s b model n=%0d", ph, j), rd_b.data, reduce(yref(1, j), 24));
    end
    rd_a.addr = 32'd63;
    rd_b.addr = 32'd63;
    #1;
    chk({ph, " a result63"}, rd_a.data, 32'd45760);
`ifdef FIR_TOP_64_SAT_EN
    chk({ph, " b result63 sat"}, rd_b.data, 32'd8388607);
`else
    chk({ph, " b result63 wrap"}, rd_b.data, 32'd1046496);
`endif
    rd_b.addr = 32'd0;
    #1;
    chk({ph, " b result0"}, rd_b.data, 32'd32767);
    rd_a.addr = 32'd64;
    rd_b.addr = 32'hFFFF_FFFF;
    #1;
    chk({ph, " a addr 64"}, rd_a.data, 32'd0);
    chk({ph, " b addr ffffffff"}, rd_b.data, 32'd0);
    rd_a.addr = 32'hFFFF_FFFF;
    rd_b.addr = 32'd64;
    #1;
    chk({ph, " a addr ffffffff"}, rd_a.data, 32'd0);
    chk({ph, " b addr 64"}, rd_b.data, 32'd0);
  endtask

  task automatic check_cleared(input string ph);
    chk({ph, " done_a"}, 32'(rd_a.done), 32'd0);
    chk({ph, " done_b"}, 32'(rd_b.done), 32'd0);
    for (int j = 0; j < 64; j += 7) begin
      rd_a.addr = 32'(j);
      rd_b.addr = 32'(63 - j);
      #1;
      chk($sformatf("%s a rd[%0d]", ph, j), rd_a.data, 32'd0);
      chk($sformatf("%s b rd[%0d]", ph, 63 - j), rd_b.data, 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    rd_a.addr = '0;
    rd_b.addr = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");

    reset = 1'b1;
    run_seq("run1", -1);
    sweep("run1");

    // Abort a second run after E30 and confirm the asynchronous clear.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_seq("run2", 30);
    reset = 1'b0;
    #1;
    check_cleared("abort");
    repeat (2) @(negedge clk);
    check_cleared("abort hold");
    reset = 1'b1;
    run_seq("run3", -1);
    sweep("run3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
